// File: rtl/bpm_mux_integrator.sv
// rtl/bpm_mux_integrator.sv - N-BPM channel mux with gated, windowed I/Q integrator
// Define BPM_INT_SAT_EN to clamp accumulators on overflow instead of wrapping.
module bpm_mux_integrator #(
    parameter int NBPM = 2,
    parameter int DW   = 13,
    parameter int ACCW = 17,
    parameter int CNTW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bunch_strb,
    input  logic                   store_strb,
    input  logic                   dac_cond,
    input  logic [NBPM-1:0]        sel,
    input  logic [(NBPM+1)*DW-1:0] ch_i,
    input  logic [(NBPM+1)*DW-1:0] ch_q,
    output logic [NBPM*ACCW-1:0]   acc_i,
    output logic [NBPM*ACCW-1:0]   acc_q,
    output logic [NBPM*ACCW-1:0]   res_i,
    output logic [NBPM*ACCW-1:0]   res_q,
    output logic [CNTW-1:0]        res_cnt,
    output logic [NBPM-1:0]        res_ovf,
    output logic                   res_valid
);

    typedef enum logic {IDLE = 1'b0, INTEG = 1'b1} state_t;

    state_t                 state;
    logic [NBPM-1:0]        sel_q;
    logic [NBPM-1:0]        sel_eff;
    logic [NBPM-1:0]        ovf;
    logic [NBPM-1:0]        ovf_hit;
    logic [NBPM*ACCW-1:0]   accr_i;
    logic [NBPM*ACCW-1:0]   accr_q;
    logic [NBPM*ACCW-1:0]   nxt_i;
    logic [NBPM*ACCW-1:0]   nxt_q;
    logic [CNTW-1:0]        cnt;
    logic                   clr;

    assign clr     = ~bunch_strb & (dac_cond | ~store_strb);
    // The first sample of a window uses the live select; later samples use the latched copy.
    assign sel_eff = (state == IDLE) ? sel : sel_q;

    genvar k;
    generate
        for (k = 0; k < NBPM; k++) begin : g_bpm
            logic [DW-1:0]          smp_i, smp_q;
            logic signed [ACCW-1:0] ext_i, ext_q, a_i, a_q, s_i, s_q;
            logic                   ov_i, ov_q;

            assign smp_i = sel_eff[k] ? ch_i[(k+1)*DW +: DW] : ch_i[k*DW +: DW];
            assign smp_q = sel_eff[k] ? ch_q[(k+1)*DW +: DW] : ch_q[k*DW +: DW];
            assign ext_i = {{(ACCW-DW){smp_i[DW-1]}}, smp_i};
            assign ext_q = {{(ACCW-DW){smp_q[DW-1]}}, smp_q};
            assign a_i   = accr_i[k*ACCW +: ACCW];
            assign a_q   = accr_q[k*ACCW +: ACCW];
            assign s_i   = a_i + ext_i;
            assign s_q   = a_q + ext_q;
            assign ov_i  = (a_i[ACCW-1] == ext_i[ACCW-1]) && (s_i[ACCW-1] != a_i[ACCW-1]);
            assign ov_q  = (a_q[ACCW-1] == ext_q[ACCW-1]) && (s_q[ACCW-1] != a_q[ACCW-1]);
            assign ovf_hit[k] = ov_i | ov_q;
`ifdef BPM_INT_SAT_EN
            localparam logic [ACCW-1:0] MAXV = {1'b0, {(ACCW-1){1'b1}}};
            localparam logic [ACCW-1:0] MINV = {1'b1, {(ACCW-1){1'b0}}};
            // On overflow the operands share a sign, so the accumulator sign picks the rail.
            assign nxt_i[k*ACCW +: ACCW] = ov_i ? (a_i[ACCW-1] ? MINV : MAXV) : s_i;
            assign nxt_q[k*ACCW +: ACCW] = ov_q ? (a_q[ACCW-1] ? MINV : MAXV) : s_q;
`else
            assign nxt_i[k*ACCW +: ACCW] = s_i;
            assign nxt_q[k*ACCW +: ACCW] = s_q;
`endif
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel_q     <= '0;
            accr_i    <= '0;
            accr_q    <= '0;
            cnt       <= '0;
            ovf       <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            res_i     <= '0;
            res_q     <= '0;
            res_cnt   <= '0;
            res_ovf   <= '0;
            res_valid <= 1'b0;
        end else begin
            acc_i     <= accr_i;
            acc_q     <= accr_q;
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bunch_strb) begin
                        accr_i <= nxt_i;
                        accr_q <= nxt_q;
                        ovf    <= ovf_hit;
                        sel_q  <= sel;
                        cnt    <= CNTW'(1);
                        state  <= INTEG;
                    end
                end
                INTEG: begin
                    if (bunch_strb) begin
                        accr_i <= nxt_i;
                        accr_q <= nxt_q;
                        ovf    <= ovf | ovf_hit;
                        if (cnt != '1)
                            cnt <= cnt + CNTW'(1);
                    end else if (clr) begin
                        // Abort clears like a publish but leaves the held results untouched.
                        if (!dac_cond) begin
                            res_i     <= accr_i;
                            res_q     <= accr_q;
                            res_cnt   <= cnt;
                            res_ovf   <= ovf;
                            res_valid <= 1'b1;
                        end
                        accr_i <= '0;
                        accr_q <= '0;
                        cnt    <= '0;
                        ovf    <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bpm_mux_integrator.sv
// tb/tb_bpm_mux_integrator.sv - self-checking bench for bpm_mux_integrator
module tb_bpm_mux_integrator;
    localparam int NBPM = 2;
    localparam int DW   = 13;
    localparam int ACCW = 17;
    localparam int CNTW = 8;
    localparam int AMAX = (1 << (ACCW-1)) - 1;
    localparam int AMIN = -(1 << (ACCW-1));
    localparam int CMAX = (1 << CNTW) - 1;
    localparam int CMAX4 = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bunch_strb = 1'b0;
    logic store_strb = 1'b0;
    logic dac_cond = 1'b0;
    logic [NBPM-1:0] sel = '0;
    logic [(NBPM+1)*DW-1:0] ch_i = '0;
    logic [(NBPM+1)*DW-1:0] ch_q = '0;

    logic [NBPM*ACCW-1:0] acc_i, acc_q, res_i, res_q;
    logic [CNTW-1:0]      res_cnt;
    logic [NBPM-1:0]      res_ovf;
    logic                 res_valid;

    logic [NBPM*ACCW-1:0] c4_acc_i, c4_acc_q, c4_res_i, c4_res_q;
    logic [3:0]           c4_res_cnt;
    logic [NBPM-1:0]      c4_res_ovf;
    logic                 c4_res_valid;

    bpm_mux_integrator #(.NBPM(NBPM), .DW(DW), .ACCW(ACCW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .bunch_strb(bunch_strb), .store_strb(store_strb),
        .dac_cond(dac_cond), .sel(sel), .ch_i(ch_i), .ch_q(ch_q),
        .acc_i(acc_i), .acc_q(acc_q), .res_i(res_i), .res_q(res_q),
        .res_cnt(res_cnt), .res_ovf(res_ovf), .res_valid(res_valid)
    );

    bpm_mux_integrator #(.NBPM(NBPM), .DW(DW), .ACCW(ACCW), .CNTW(4)) dut_c4 (
        .clk(clk), .rst(rst), .bunch_strb(bunch_strb), .store_strb(store_strb),
        .dac_cond(dac_cond), .sel(sel), .ch_i(ch_i), .ch_q(ch_q),
        .acc_i(c4_acc_i), .acc_q(c4_acc_q), .res_i(c4_res_i), .res_q(c4_res_q),
        .res_cnt(c4_res_cnt), .res_ovf(c4_res_ovf), .res_valid(c4_res_valid)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int smp(input logic [(NBPM+1)*DW-1:0] v, input int c);
        logic [DW-1:0] t;
        t = v[c*DW +: DW];
        return int'($signed(t));
    endfunction

    function automatic int slc(input logic [NBPM*ACCW-1:0] v, input int k);
        logic [ACCW-1:0] t;
        t = v[k*ACCW +: ACCW];
        return int'($signed(t));
    endfunction

    // Exact integer sum, then the representable-range rule decides overflow and wrap/clamp.
    function automatic int madd(input int a, input int x, output bit o);
        int s;
        s = a + x;
        o = (s > AMAX) || (s < AMIN);
`ifdef BPM_INT_SAT_EN
        if (s > AMAX) s = AMAX;
        else if (s < AMIN) s = AMIN;
`else
        if (s > AMAX) s -= (1 << ACCW);
        else if (s < AMIN) s += (1 << ACCW);
`endif
        return s;
    endfunction

    int m_i [NBPM];
    int m_q [NBPM];
    int e_acc_i [NBPM];
    int e_acc_q [NBPM];
    int e_res_i [NBPM];
    int e_res_q [NBPM];
    int m_cnt, e_cnt, e_cnt4;
    bit m_act, e_valid;
    bit [NBPM-1:0] m_sel, m_ovf, e_ovf, m_su;
    bit m_o;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int k = 0; k < NBPM; k++) begin
                m_i[k] = 0; m_q[k] = 0; e_acc_i[k] = 0; e_acc_q[k] = 0;
                e_res_i[k] = 0; e_res_q[k] = 0;
            end
            m_cnt = 0; e_cnt = 0; e_cnt4 = 0; m_act = 0; e_valid = 0;
            m_sel = '0; m_ovf = '0; e_ovf = '0;
        end else begin
            for (int k = 0; k < NBPM; k++) begin
                e_acc_i[k] = m_i[k];
                e_acc_q[k] = m_q[k];
            end
            e_valid = 0;
            if (bunch_strb) begin
                m_su = m_act ? m_sel : sel;
                if (!m_act) begin
                    m_sel = sel; m_cnt = 0; m_ovf = '0;
                end
                for (int k = 0; k < NBPM; k++) begin
                    m_i[k] = madd(m_i[k], smp(ch_i, k + int'(m_su[k])), m_o);
                    m_ovf[k] = m_ovf[k] | m_o;
                    m_q[k] = madd(m_q[k], smp(ch_q, k + int'(m_su[k])), m_o);
                    m_ovf[k] = m_ovf[k] | m_o;
                end
                m_cnt++;
                m_act = 1;
            end else if (m_act && (dac_cond || !store_strb)) begin
                if (!dac_cond) begin
                    for (int k = 0; k < NBPM; k++) begin
                        e_res_i[k] = m_i[k];
                        e_res_q[k] = m_q[k];
                    end
                    e_cnt  = (m_cnt > CMAX) ? CMAX : m_cnt;
                    e_cnt4 = (m_cnt > CMAX4) ? CMAX4 : m_cnt;
                    e_ovf  = m_ovf;
                    e_valid = 1;
                end
                for (int k = 0; k < NBPM; k++) begin
                    m_i[k] = 0; m_q[k] = 0;
                end
                m_cnt = 0; m_ovf = '0; m_act = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int k = 0; k < NBPM; k++) begin
                chk($sformatf("acc_i[%0d]", k), slc(acc_i, k), e_acc_i[k]);
                chk($sformatf("acc_q[%0d]", k), slc(acc_q, k), e_acc_q[k]);
                chk($sformatf("res_i[%0d]", k), slc(res_i, k), e_res_i[k]);
                chk($sformatf("res_q[%0d]", k), slc(res_q, k), e_res_q[k]);
                chk($sformatf("c4_acc_i[%0d]", k), slc(c4_acc_i, k), e_acc_i[k]);
                chk($sformatf("c4_acc_q[%0d]", k), slc(c4_acc_q, k), e_acc_q[k]);
                chk($sformatf("c4_res_i[%0d]", k), slc(c4_res_i, k), e_res_i[k]);
                chk($sformatf("c4_res_q[%0d]", k), slc(c4_res_q, k), e_res_q[k]);
            end
            chk("res_cnt", int'(res_cnt), e_cnt);
            chk("res_ovf", int'(res_ovf), int'(e_ovf));
            chk("res_valid", int'(res_valid), int'(e_valid));
            chk("c4_res_cnt", int'(c4_res_cnt), e_cnt4);
            chk("c4_res_ovf", int'(c4_res_ovf), int'(e_ovf));
            chk("c4_res_valid", int'(c4_res_valid), int'(e_valid));
        end
    end

    task automatic step(input bit b, input bit s, input bit d);
        bunch_strb = b;
        store_strb = s;
        dac_cond   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic setch(input int c, input int vi, input int vq);
        ch_i[c*DW +: DW] = DW'(vi);
        ch_q[c*DW +: DW] = DW'(vq);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset acc_i", slc(acc_i, 0), 0);
        chk("reset res_valid", int'(res_valid), 0);
        chk("reset res_cnt", int'(res_cnt), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // select latch
        setch(0, 100, 3); setch(1, -50, -4); setch(2, 0, 0);
        sel = 2'b00;
        step(1, 1, 0);
        sel = 2'b11;
        repeat (3) step(1, 1, 0);
        step(0, 0, 0);
        chk("latch res_i0", slc(res_i, 0), 400);
        chk("latch res_i1", slc(res_i, 1), -200);
        chk("latch res_cnt", int'(res_cnt), 4);
        chk("latch res_valid", int'(res_valid), 1);
        step(0, 0, 0);
        chk("latch res_valid pulse", int'(res_valid), 0);

        // abort
        sel = 2'b01; setch(1, 7, 0);
        repeat (3) step(1, 1, 0);
        step(0, 1, 1);
        chk("abort res_valid", int'(res_valid), 0);
        chk("abort res_i0 held", slc(res_i, 0), 400);
        chk("abort acc_i pre", slc(acc_i, 0), 21);
        step(0, 1, 0);
        chk("abort acc_i cleared", slc(acc_i, 0), 0);
        step(0, 0, 0);
        chk("abort no publish", int'(res_valid), 0);

        // bunch_strb over clr priority
        sel = 2'b00; setch(0, 10, 0);
        step(1, 1, 0);
        setch(0, 5, 0);
        step(1, 0, 0);
        chk("prio no publish", int'(res_valid), 0);
        step(0, 0, 0);
        chk("prio res_i", slc(res_i, 0), 15);
        chk("prio acc_i", slc(acc_i, 0), 15);
        chk("prio res_valid", int'(res_valid), 1);

        // overflow
        setch(0, 4095, 0);
        repeat (17) step(1, 1, 0);
        step(0, 0, 0);
`ifdef BPM_INT_SAT_EN
        chk("ovf res_i", slc(res_i, 0), 65535);
`else
        chk("ovf res_i", slc(res_i, 0), -61457);
`endif
        chk("ovf flag", int'(res_ovf[0]), 1);

        // count saturation
        setch(0, 1, 0);
        repeat (20) step(1, 1, 0);
        step(0, 0, 0);
        chk("cnt8 res_cnt", int'(res_cnt), 20);
        chk("cnt4 res_cnt", int'(c4_res_cnt), 15);
        chk("cnt4 res_i", slc(c4_res_i, 0), 20);

        // reset mid-window
        setch(0, 9, 0);
        repeat (2) step(1, 1, 0);
        rst = 1'b1;
        #1;
        chk("rst res_i", slc(res_i, 0), 0);
        chk("rst res_cnt", int'(res_cnt), 0);
        chk("rst acc_i", slc(acc_i, 0), 0);
        chk("rst res_valid", int'(res_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        setch(0, 3, 0);
        repeat (2) step(1, 1, 0);
        step(0, 0, 0);
        chk("post-rst res_i", slc(res_i, 0), 6);
        chk("post-rst res_valid", int'(res_valid), 1);

        // randomized traffic, alternating mild and overflow-prone phases
        for (int n = 0; n < 4000; n++) begin
            sel = NBPM'($urandom);
            for (int c = 0; c <= NBPM; c++) begin
                if ((n / 500) % 2 == 1)
                    setch(c, int'($urandom_range(3000, 4095)), -int'($urandom_range(3000, 4096)));
                else
                    setch(c, int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)));
            end
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                step(0, 0, 0);
                rst = 1'b0;
            end else begin
                step(($urandom % 4) != 0, ($urandom % 32) != 0, ($urandom % 20) == 0);
            end
        end
        step(0, 0, 0);
        step(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
